// File: rtl/oam_dma_if.sv
// ---------------------------------------------------------------------------
// oam_dma_if -- bus bundle between the CPU-side bus, the system bus mux and
// the sprite DMA engine.
//
// Signals (direction as seen by the DMA engine, modport slave):
//   cpu_addr    in  16  CPU address output
//   cpu_dout    in   8  CPU write data (valid when cpu_rw=0)
//   cpu_rw      in   1  CPU read/write strobe, 1=read
//   bus_din     in   8  data returned by the system bus on read cycles
//   ready       out  1  to CPU ready input; 0 requests halt
//   dma_act     out  1  bus mux select; 1 = DMA owns address/data/rw
//   dma_addr    out 16  DMA bus address
//   dma_dout    out  8  DMA write data
//   dma_rw      out  1  DMA strobe, 1=read
//   busy        out  1  high from trigger until the transfer completes
//   dbg_state   out  3  current FSM state encoding (debug)
//   dbg_cyc_odd out  1  free-running cycle parity (debug)
//
// Handshake: ready is a level-sensitive halt request, not a valid/ready
// pair. While ready=0 the CPU completes any write cycles it has in flight
// and then stalls on its next read cycle; the DMA only drives the bus
// (dma_act=1) once such a read cycle has been seen.
// ---------------------------------------------------------------------------
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic [7:0]  bus_din;
  logic        ready;
  logic        dma_act;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_rw;
  logic        busy;
  logic [2:0]  dbg_state;
  logic        dbg_cyc_odd;

  // DMA engine side
  modport slave (
    input  cpu_addr, cpu_dout, cpu_rw, bus_din,
    output ready, dma_act, dma_addr, dma_dout, dma_rw, busy,
    output dbg_state, dbg_cyc_odd
  );

  // CPU / system bus side
  modport master (
    output cpu_addr, cpu_dout, cpu_rw, bus_din,
    input  ready, dma_act, dma_addr, dma_dout, dma_rw, busy,
    input  dbg_state, dbg_cyc_odd
  );
endinterface

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma -- sprite DMA engine sitting on the CPU external bus.
//
// A CPU write to REG_ADDR latches a source page and halts the CPU. After the
// CPU's first read (dummy) cycle, and an optional one-cycle alignment so that
// every read lands on an even cycle, the engine copies 256 bytes from
// {page,00..FF} to DEST_ADDR as strictly alternating read/write bus cycles,
// then releases the CPU.
//
// Ports:
//   dclk     in   bus clock, all state updates on the rising edge
//   n_reset  in   asynchronous, active-low reset
//   bus      oam_dma_if.slave  (CPU snoop inputs, bus_din, DMA bus outputs,
//                               ready/busy, debug state)
// All outputs are registered.
// ---------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] REG_ADDR  = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic     dclk,
  input  logic     n_reset,
  oam_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_idx, w_idx_nx;
  logic [7:0]  r_page, w_page_nx;
  logic        r_cyc_odd;
  logic        r_ready, w_ready_nx;
  logic        r_busy, w_busy_nx;
  logic        r_act, w_act_nx;
  logic        r_rw, w_rw_nx;
  logic [15:0] r_addr, w_addr_nx;
  logic [7:0]  r_dout, w_dout_nx;   // doubles as the read-to-write byte buffer
  logic        w_trigger;

  assign w_trigger = (bus.cpu_rw == 1'b0) && (bus.cpu_addr == REG_ADDR);

  // Free-running parity; never gated by the transfer.
  always_ff @(posedge dclk or negedge n_reset) begin
    if (!n_reset) r_cyc_odd <= 1'b0;
    else          r_cyc_odd <= ~r_cyc_odd;
  end

  always_ff @(posedge dclk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_idx   <= 8'h00;
      r_page  <= 8'h00;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_act   <= 1'b0;
      r_rw    <= 1'b1;
      r_addr  <= 16'h0000;
      r_dout  <= 8'h00;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_page  <= w_page_nx;
      r_ready <= w_ready_nx;
      r_busy  <= w_busy_nx;
      r_act   <= w_act_nx;
      r_rw    <= w_rw_nx;
      r_addr  <= w_addr_nx;
      r_dout  <= w_dout_nx;
    end
  end

  // Outputs are registered, so each branch sets up what the bus must show
  // during the state being entered.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_page_nx  = r_page;
    w_ready_nx = r_ready;
    w_busy_nx  = r_busy;
    w_act_nx   = r_act;
    w_rw_nx    = r_rw;
    w_addr_nx  = r_addr;
    w_dout_nx  = r_dout;

    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_nx = S_HALT;
          w_page_nx  = bus.cpu_dout;
          w_idx_nx   = 8'h00;
          w_ready_nx = 1'b0;
          w_busy_nx  = 1'b1;
        end
      end

      S_HALT: begin
        // CPU writes cannot be stalled; wait for its first read (dummy)
        // cycle. An even dummy cycle means the next cycle is odd, so one
        // ALIGN cycle is inserted to keep reads on even cycles.
        if (bus.cpu_rw) begin
          if (r_cyc_odd) begin
            w_state_nx = S_READ;
            w_act_nx   = 1'b1;
            w_rw_nx    = 1'b1;
            w_addr_nx  = {r_page, r_idx};
          end else begin
            w_state_nx = S_ALIGN;
          end
        end
      end

      S_ALIGN: begin
        w_state_nx = S_READ;
        w_act_nx   = 1'b1;
        w_rw_nx    = 1'b1;
        w_addr_nx  = {r_page, r_idx};
      end

      S_READ: begin
        w_state_nx = S_WRITE;
        w_rw_nx    = 1'b0;
        w_addr_nx  = DEST_ADDR;
        w_dout_nx  = bus.bus_din;
      end

      S_WRITE: begin
        w_idx_nx = r_idx + 8'd1;
        if (r_idx == 8'hFF) begin
          w_state_nx = S_IDLE;
          w_ready_nx = 1'b1;
          w_busy_nx  = 1'b0;
          w_act_nx   = 1'b0;
          w_rw_nx    = 1'b1;
        end else begin
          w_state_nx = S_READ;
          w_rw_nx    = 1'b1;
          w_addr_nx  = {r_page, w_idx_nx};
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.ready       = r_ready;
  assign bus.busy        = r_busy;
  assign bus.dma_act     = r_act;
  assign bus.dma_rw      = r_rw;
  assign bus.dma_addr    = r_addr;
  assign bus.dma_dout    = r_dout;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_cyc_odd = r_cyc_odd;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma -- directed bench for oam_dma. The bench plays CPU and system
// RAM; a negedge monitor records one trace entry per bus cycle and each
// transfer is checked from that trace against values derived from the
// source memory image and the expected halt length.
// ---------------------------------------------------------------------------
module tb_oam_dma;

  logic dclk;
  logic n_reset;

  oam_dma_if bif ();

  oam_dma #(
    .REG_ADDR  (16'h4014),
    .DEST_ADDR (16'h2004)
  ) dut (
    .dclk    (dclk),
    .n_reset (n_reset),
    .bus     (bif.slave)
  );

  // ---------------- clock / reset ----------------
  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- system bus model ----------------
  logic [7:0]  mem [0:65535];
  logic [15:0] w_mux_addr;
  assign w_mux_addr  = bif.dma_act ? bif.dma_addr : bif.cpu_addr;
  assign bif.bus_din = mem[w_mux_addr];

  // Reference parity: toggles every edge from reset.
  logic tb_odd;
  always @(posedge dclk or negedge n_reset) begin
    if (!n_reset) tb_odd <= 1'b0;
    else          tb_odd <= ~tb_odd;
  end

  // ---------------- monitor ----------------
  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        act;
    logic        rw;
    logic        cpu_rw;
    logic        odd;
    logic [15:0] addr;
    logic [7:0]  dout;
  } ent_t;

  ent_t trace[$];
  logic mon_clr;

  always @(negedge dclk) begin
    if (mon_clr) trace.delete();
    else if (n_reset) trace.push_back('{bif.ready, bif.busy, bif.dma_act, bif.dma_rw,
                                        bif.cpu_rw, tb_odd, bif.dma_addr, bif.dma_dout});
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;
  logic [15:0] rd_a[$];
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                       output bit ok);
    n_cmp++;
    ok = 1'b1;
    assert (obs === exp) else begin
      n_err++;
      ok = 1'b0;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_cycle(input logic [15:0] addr, input logic [7:0] data, input logic rw);
    bif.cpu_addr = addr;
    bif.cpu_dout = data;
    bif.cpu_rw   = rw;
    @(posedge dclk);
    #1;
  endtask

  // Insert an idle read so that the dummy cycle following a trigger plus
  // k halt writes falls on parity want_odd.
  task automatic align_to(input logic want_odd, input int k);
    logic p;
    p = tb_odd ^ logic'((k + 1) % 2);
    if (p != want_odd) cpu_cycle(16'h8000, 8'h00, 1'b1);
  endtask

  task automatic trigger(input logic [7:0] page, input int k);
    mon_clr = 1'b1;
    cpu_cycle(16'h4014, page, 1'b0);
    mon_clr = 1'b0;
    for (int i = 0; i < k; i++) cpu_cycle(16'h4000, 8'hEE, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit ok;
    n = 0;
    while (bif.ready !== 1'b1 && n < 2000) begin
      cpu_cycle(16'h8000, 8'h00, 1'b1);
      n++;
    end
    check({tag, ".done"}, {31'd0, bif.ready}, 32'd1, ok);
  endtask

  task automatic analyze(input string tag, input logic [7:0] page, input int exp_low);
    int n_low, alt_err, odd_err, ovl_err, busy_err;
    bit prev_rd;
    bit ok;
    logic [15:0] ea;
    n_low = 0; alt_err = 0; odd_err = 0; ovl_err = 0; busy_err = 0;
    prev_rd = 1'b0;
    rd_a.delete(); wr_a.delete(); wr_d.delete();
    foreach (trace[i]) begin
      if (!trace[i].ready) n_low++;
      if (trace[i].busy === trace[i].ready) busy_err++;
      if (trace[i].act) begin
        if (!trace[i].cpu_rw) ovl_err++;
        if (trace[i].rw) begin
          rd_a.push_back(trace[i].addr);
          if (trace[i].odd) odd_err++;
          if (prev_rd) alt_err++;
          prev_rd = 1'b1;
        end else begin
          wr_a.push_back(trace[i].addr);
          wr_d.push_back(trace[i].dout);
          if (!prev_rd) alt_err++;
          prev_rd = 1'b0;
        end
      end
    end
    check({tag, ".ready_drop"}, {31'd0, (trace.size() > 0) ? trace[0].ready : 1'bx}, 32'd0, ok);
    check({tag, ".halt_len"}, n_low, exp_low, ok);
    check({tag, ".n_reads"}, rd_a.size(), 256, ok);
    check({tag, ".n_writes"}, wr_a.size(), 256, ok);
    check({tag, ".alternate"}, alt_err, 0, ok);
    check({tag, ".read_even"}, odd_err, 0, ok);
    check({tag, ".no_overlap"}, ovl_err, 0, ok);
    check({tag, ".busy_vs_ready"}, busy_err, 0, ok);
    for (int i = 0; i < 256 && i < rd_a.size(); i++) begin
      ea = {page, 8'(i)};
      check({tag, ".rd_addr"}, {16'd0, rd_a[i]}, {16'd0, ea}, ok);
      if (!ok) break;
    end
    for (int i = 0; i < 256 && i < wr_a.size(); i++) begin
      ea = {page, 8'(i)};
      check({tag, ".wr_addr_data"}, {8'd0, wr_a[i], wr_d[i]}, {8'd0, 16'h2004, mem[ea]}, ok);
      if (!ok) break;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int nw;
    logic p;
    n_cmp = 0;
    n_err = 0;
    mon_clr = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0300 + i] = 8'(i * 7 + 3);
      mem[16'h0700 + i] = ~8'(i);
    end
    bif.cpu_addr = 16'h0000;
    bif.cpu_dout = 8'h00;
    bif.cpu_rw   = 1'b1;
    n_reset = 1'b0;

    // Reset values
    repeat (3) @(posedge dclk);
    #1;
    check("rst.ready",    {31'd0, bif.ready},   32'd1, ok);
    check("rst.dma_act",  {31'd0, bif.dma_act}, 32'd0, ok);
    check("rst.dma_addr", {16'd0, bif.dma_addr}, 32'h0, ok);
    check("rst.dma_dout", {24'd0, bif.dma_dout}, 32'h0, ok);
    check("rst.dma_rw",   {31'd0, bif.dma_rw},  32'd1, ok);
    check("rst.busy",     {31'd0, bif.busy},    32'd0, ok);
    check("rst.state",    {29'd0, bif.dbg_state}, 32'd0, ok);
    check("rst.cyc_odd",  {31'd0, bif.dbg_cyc_odd}, 32'd0, ok);
    n_reset = 1'b1;
    repeat (3) cpu_cycle(16'h8000, 8'h00, 1'b1);
    check("parity", {31'd0, bif.dbg_cyc_odd}, {31'd0, tb_odd}, ok);

    // Decode: neighbouring addresses and a read of the trigger address
    mon_clr = 1'b1;
    cpu_cycle(16'h4013, 8'h02, 1'b0);
    mon_clr = 1'b0;
    cpu_cycle(16'h4015, 8'h02, 1'b0);
    cpu_cycle(16'h4014, 8'h02, 1'b1);
    repeat (3) cpu_cycle(16'h8000, 8'h00, 1'b1);
    nw = 0;
    foreach (trace[i]) if (!trace[i].ready || trace[i].busy || trace[i].act) nw++;
    check("decode.idle_samples", nw, 0, ok);
    check("decode.n_samples", trace.size(), 5, ok);
    check("decode.state", {29'd0, bif.dbg_state}, 32'd0, ok);

    // Basic transfer, dummy cycle odd: no align, 513 halted cycles
    align_to(1'b1, 0);
    trigger(8'h02, 0);
    wait_done("basic");
    analyze("basic", 8'h02, 513);
    check("basic.wr0", {24'd0, (wr_d.size() > 0)   ? wr_d[0]   : 8'hxx}, 32'h5A, ok);
    check("basic.wr1", {24'd0, (wr_d.size() > 1)   ? wr_d[1]   : 8'hxx}, 32'h5B, ok);
    check("basic.wr255", {24'd0, (wr_d.size() > 255) ? wr_d[255] : 8'hxx}, 32'hA5, ok);
    check("basic.rd255", {16'd0, (rd_a.size() > 255) ? rd_a[255] : 16'hxxxx}, 32'h02FF, ok);
    check("hold.dma_dout", {24'd0, bif.dma_dout}, 32'hA5, ok);
    check("hold.dma_addr", {16'd0, bif.dma_addr}, 32'h2004, ok);
    check("hold.dma_rw",   {31'd0, bif.dma_rw},   32'd1, ok);
    check("hold.busy",     {31'd0, bif.busy},     32'd0, ok);

    // Back-to-back: trigger in the very first idle cycle
    p = ~tb_odd;
    trigger(8'h07, 0);
    wait_done("b2b");
    analyze("b2b", 8'h07, p ? 513 : 514);
    check("b2b.first_rd", {16'd0, (rd_a.size() > 0) ? rd_a[0] : 16'hxxxx}, 32'h0700, ok);
    check("b2b.first_wr", {24'd0, (wr_d.size() > 0) ? wr_d[0] : 8'hxx}, 32'hFF, ok);

    // Alignment: dummy cycle even, one ALIGN cycle, 514 halted cycles
    repeat (2) cpu_cycle(16'h8000, 8'h00, 1'b1);
    align_to(1'b0, 0);
    trigger(8'h02, 0);
    wait_done("align");
    analyze("align", 8'h02, 514);

    // Write-extended halt: three CPU writes after the trigger
    align_to(1'b1, 3);
    trigger(8'h03, 3);
    wait_done("wext_odd");
    analyze("wext_odd", 8'h03, 516);
    repeat (2) cpu_cycle(16'h8000, 8'h00, 1'b1);
    align_to(1'b0, 3);
    trigger(8'h03, 3);
    wait_done("wext_even");
    analyze("wext_even", 8'h03, 517);

    // Reset after 100 bytes
    align_to(1'b1, 0);
    trigger(8'h02, 0);
    repeat (201) cpu_cycle(16'h8000, 8'h00, 1'b1);
    nw = 0;
    foreach (trace[i]) if (trace[i].act && !trace[i].rw) nw++;
    check("mid.bytes_done", nw, 100, ok);
    check("mid.busy",     {31'd0, bif.busy},     32'd1, ok);
    check("mid.dma_addr", {16'd0, bif.dma_addr}, 32'h0264, ok);
    check("mid.dma_rw",   {31'd0, bif.dma_rw},   32'd1, ok);
    n_reset = 1'b0;
    #1;
    check("mid.rst_ready",   {31'd0, bif.ready},   32'd1, ok);
    check("mid.rst_dma_act", {31'd0, bif.dma_act}, 32'd0, ok);
    check("mid.rst_busy",    {31'd0, bif.busy},    32'd0, ok);
    check("mid.rst_state",   {29'd0, bif.dbg_state}, 32'd0, ok);
    @(posedge dclk);
    #1;
    n_reset = 1'b1;
    cpu_cycle(16'h8000, 8'h00, 1'b1);
    check("mid.no_resume", {31'd0, bif.dma_act}, 32'd0, ok);
    align_to(1'b0, 0);
    trigger(8'h03, 0);
    wait_done("post_rst");
    analyze("post_rst", 8'h03, 514);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
